// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates tags at dispatch, collects writebacks, retires in order,
// and squashes everything younger than a mispredicting branch.
module reorder_buffer #(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned TAG_W  = $clog2(DEPTH),
   parameter int unsigned PREG_W = 7,
   parameter int unsigned AREG_W = 5,
   parameter int unsigned NUM_WB = 3
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    alloc_valid_in,
   output logic                    alloc_ready_out,
   input  logic                    alloc_has_rd,
   input  logic [AREG_W-1:0]       alloc_areg,
   input  logic [PREG_W-1:0]       alloc_pd_new,
   input  logic [PREG_W-1:0]       alloc_pd_old,
   output logic [TAG_W-1:0]        alloc_tag_out,
   input  logic [NUM_WB-1:0]       wb_valid,
   input  logic [NUM_WB*TAG_W-1:0] wb_tag,
   input  logic                    br_mispredict,
   input  logic [TAG_W-1:0]        br_mispredict_tag,
   output logic                    commit_valid_out,
   output logic                    commit_has_rd,
   output logic [AREG_W-1:0]       commit_areg,
   output logic [PREG_W-1:0]       commit_pd_new,
   output logic [PREG_W-1:0]       commit_pd_old,
   output logic [TAG_W-1:0]        curr_rob_tag,
   output logic [TAG_W:0]          count_out,
   output logic                    empty_out,
   output logic                    full_out
);

   localparam int unsigned CNT_W = TAG_W + 1;

   typedef struct packed {
      logic              has_rd;
      logic [AREG_W-1:0] areg;
      logic [PREG_W-1:0] pd_new;
      logic [PREG_W-1:0] pd_old;
   } entry_t;

   logic [DEPTH-1:0] valid_q, valid_d;
   logic [DEPTH-1:0] done_q, done_d;
   entry_t           payload_q [DEPTH];
   logic [TAG_W-1:0] head_q, head_d;
   logic [TAG_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic             commit;
   logic             flush;
   logic             alloc;
   logic             ready;
   logic [TAG_W-1:0] br_age;
   logic [TAG_W-1:0] age_i;

   // Handshake and retire/flush decisions for this cycle
   always_comb begin
      commit = valid_q[head_q] && done_q[head_q];
      flush  = br_mispredict && valid_q[br_mispredict_tag];
      ready  = (count_q < CNT_W'(DEPTH)) && !br_mispredict;
      alloc  = alloc_valid_in && ready;
      br_age = TAG_W'(br_mispredict_tag - head_q);
   end

   // Per-entry status update; later rules override earlier ones
   always_comb begin
      valid_d = valid_q;
      done_d  = done_q;
      age_i   = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         age_i = TAG_W'(TAG_W'(i) - head_q);
         for (int unsigned ch = 0; ch < NUM_WB; ch++) begin
            if (wb_valid[ch] && (wb_tag[ch*TAG_W +: TAG_W] == TAG_W'(i)) && valid_q[i]) begin
               done_d[i] = 1'b1;
            end
         end
         if (flush && (age_i > br_age)) begin
            valid_d[i] = 1'b0;
            done_d[i]  = 1'b0;
         end
         if (commit && (TAG_W'(i) == head_q)) begin
            valid_d[i] = 1'b0;
            done_d[i]  = 1'b0;
         end
         if (alloc && (TAG_W'(i) == tail_q)) begin
            valid_d[i] = 1'b1;
            done_d[i]  = 1'b0;
         end
      end
   end

   // Pointer and occupancy update
   always_comb begin
      head_d  = commit ? TAG_W'(head_q + TAG_W'(1)) : head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         tail_d  = TAG_W'(br_mispredict_tag + TAG_W'(1));
         count_d = CNT_W'(CNT_W'(br_age) + CNT_W'(1) - CNT_W'(commit));
      end else begin
         if (alloc) begin
            tail_d = TAG_W'(tail_q + TAG_W'(1));
         end
         count_d = CNT_W'(count_q + CNT_W'(alloc) - CNT_W'(commit));
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= '0;
         done_q  <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            payload_q[i] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         done_q  <= done_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         if (alloc) begin
            payload_q[tail_q] <= {alloc_has_rd, alloc_areg, alloc_pd_new, alloc_pd_old};
         end
      end
   end

   // Commit fields are held at zero whenever nothing retires
   always_comb begin
      alloc_ready_out  = ready;
      alloc_tag_out    = tail_q;
      commit_valid_out = commit;
      commit_has_rd    = commit ? payload_q[head_q].has_rd : 1'b0;
      commit_areg      = commit ? payload_q[head_q].areg   : '0;
      commit_pd_new    = commit ? payload_q[head_q].pd_new : '0;
      commit_pd_old    = commit ? payload_q[head_q].pd_old : '0;
      curr_rob_tag     = head_q;
      count_out        = count_q;
      empty_out        = (count_q == '0);
      full_out         = (count_q == CNT_W'(DEPTH));
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: a program-order queue models live entries and
// done bits; directed scenarios plus a random phase drive it.
`timescale 1ns/1ps
module tb_reorder_buffer;

   localparam int unsigned DEPTH  = 16;
   localparam int unsigned TAG_W  = 4;
   localparam int unsigned PREG_W = 7;
   localparam int unsigned AREG_W = 5;
   localparam int unsigned NUM_WB = 3;

   logic                    clk = 1'b0;
   logic                    reset;
   logic                    alloc_valid_in;
   logic                    alloc_ready_out;
   logic                    alloc_has_rd;
   logic [AREG_W-1:0]       alloc_areg;
   logic [PREG_W-1:0]       alloc_pd_new;
   logic [PREG_W-1:0]       alloc_pd_old;
   logic [TAG_W-1:0]        alloc_tag_out;
   logic [NUM_WB-1:0]       wb_valid;
   logic [NUM_WB*TAG_W-1:0] wb_tag;
   logic                    br_mispredict;
   logic [TAG_W-1:0]        br_mispredict_tag;
   logic                    commit_valid_out;
   logic                    commit_has_rd;
   logic [AREG_W-1:0]       commit_areg;
   logic [PREG_W-1:0]       commit_pd_new;
   logic [PREG_W-1:0]       commit_pd_old;
   logic [TAG_W-1:0]        curr_rob_tag;
   logic [TAG_W:0]          count_out;
   logic                    empty_out;
   logic                    full_out;

   reorder_buffer #(
      .DEPTH(DEPTH), .TAG_W(TAG_W), .PREG_W(PREG_W), .AREG_W(AREG_W), .NUM_WB(NUM_WB)
   ) dut (
      .clk(clk), .reset(reset),
      .alloc_valid_in(alloc_valid_in), .alloc_ready_out(alloc_ready_out),
      .alloc_has_rd(alloc_has_rd), .alloc_areg(alloc_areg),
      .alloc_pd_new(alloc_pd_new), .alloc_pd_old(alloc_pd_old),
      .alloc_tag_out(alloc_tag_out),
      .wb_valid(wb_valid), .wb_tag(wb_tag),
      .br_mispredict(br_mispredict), .br_mispredict_tag(br_mispredict_tag),
      .commit_valid_out(commit_valid_out), .commit_has_rd(commit_has_rd),
      .commit_areg(commit_areg), .commit_pd_new(commit_pd_new), .commit_pd_old(commit_pd_old),
      .curr_rob_tag(curr_rob_tag), .count_out(count_out),
      .empty_out(empty_out), .full_out(full_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [TAG_W-1:0]  tag;
      logic              has_rd;
      logic [AREG_W-1:0] areg;
      logic [PREG_W-1:0] pd_new;
      logic [PREG_W-1:0] pd_old;
   } exp_t;

   exp_t             sb_q[$];
   logic [DEPTH-1:0] m_done;
   logic [TAG_W-1:0] m_tail;
   int               n_cmp = 0;
   int               n_err = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   function automatic int find_idx(input logic [TAG_W-1:0] t);
      for (int i = 0; i < sb_q.size(); i++) begin
         if (sb_q[i].tag == t) return i;
      end
      return -1;
   endfunction

   // Reference model: checks current outputs, then applies this cycle's events
   logic             exp_commit;
   logic             m_ready;
   int               fidx;
   int               widx;
   logic [TAG_W-1:0] wt;
   exp_t             e;
   always @(negedge clk) begin
      if (!reset) begin
         sb_q.delete();
         m_tail = '0;
         m_done = '0;
      end else begin
         exp_commit = (sb_q.size() > 0) && m_done[sb_q[0].tag];
         m_ready    = (sb_q.size() < DEPTH) && !br_mispredict;
         check("count", 32'(count_out), 32'(sb_q.size()));
         check("commit_valid", 32'(commit_valid_out), 32'(exp_commit));
         check("empty", 32'(empty_out), 32'(sb_q.size() == 0));
         check("full", 32'(full_out), 32'(sb_q.size() == DEPTH));
         check("ready", 32'(alloc_ready_out), 32'(m_ready));
         if (alloc_valid_in && m_ready) check("alloc_tag", 32'(alloc_tag_out), 32'(m_tail));
         if (exp_commit && commit_valid_out) begin
            check("commit_tag", 32'(curr_rob_tag), 32'(sb_q[0].tag));
            check("commit_has_rd", 32'(commit_has_rd), 32'(sb_q[0].has_rd));
            check("commit_areg", 32'(commit_areg), 32'(sb_q[0].areg));
            check("commit_pd_new", 32'(commit_pd_new), 32'(sb_q[0].pd_new));
            check("commit_pd_old", 32'(commit_pd_old), 32'(sb_q[0].pd_old));
         end
         fidx = br_mispredict ? find_idx(br_mispredict_tag) : -1;
         for (int ch = 0; ch < int'(NUM_WB); ch++) begin
            if (wb_valid[ch]) begin
               wt   = wb_tag[ch*TAG_W +: TAG_W];
               widx = find_idx(wt);
               if (widx >= 0 && (fidx < 0 || widx <= fidx)) m_done[wt] = 1'b1;
            end
         end
         if (fidx >= 0) begin
            while (sb_q.size() > fidx + 1) void'(sb_q.pop_back());
            m_tail = TAG_W'(br_mispredict_tag + 1);
         end
         if (exp_commit) void'(sb_q.pop_front());
         if (alloc_valid_in && m_ready) begin
            e.tag = m_tail; e.has_rd = alloc_has_rd; e.areg = alloc_areg;
            e.pd_new = alloc_pd_new; e.pd_old = alloc_pd_old;
            sb_q.push_back(e);
            m_done[m_tail] = 1'b0;
            m_tail = TAG_W'(m_tail + 1);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      alloc_valid_in = 1'b0;
      wb_valid       = '0;
      br_mispredict  = 1'b0;
   endtask

   task automatic rand_payload();
      alloc_has_rd = 1'($urandom);
      alloc_areg   = AREG_W'($urandom);
      alloc_pd_new = PREG_W'($urandom);
      alloc_pd_old = PREG_W'($urandom);
   endtask

   task automatic alloc_n(input int n);
      for (int i = 0; i < n; i++) begin
         alloc_valid_in = 1'b1;
         rand_payload();
         step();
      end
      alloc_valid_in = 1'b0;
   endtask

   task automatic wb1(input int ch, input logic [TAG_W-1:0] t);
      wb_valid = '0;
      wb_valid[ch] = 1'b1;
      wb_tag[ch*TAG_W +: TAG_W] = t;
      step();
      wb_valid = '0;
   endtask

   task automatic do_reset();
      clr();
      reset = 1'b0;
      step();
      step();
      reset = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b0;
      clr();
      rand_payload();
      wb_tag = '0;
      br_mispredict_tag = '0;
      step();
      step();
      check("rst_ready", 32'(alloc_ready_out), 32'd1);
      check("rst_alloc_tag", 32'(alloc_tag_out), 32'd0);
      check("rst_commit", 32'({commit_valid_out, commit_has_rd, commit_areg, commit_pd_new, commit_pd_old}), 32'd0);
      check("rst_head", 32'(curr_rob_tag), 32'd0);
      check("rst_count", 32'(count_out), 32'd0);
      check("rst_empty", 32'(empty_out), 32'd1);
      check("rst_full", 32'(full_out), 32'd0);
      reset = 1'b1;
      step();

      // reset with live entries
      alloc_n(4);
      check("t1_live", 32'(count_out), 32'd4);
      reset = 1'b0;
      step();
      check("t1_count", 32'(count_out), 32'd0);
      check("t1_empty", 32'(empty_out), 32'd1);
      check("t1_commit", 32'(commit_valid_out), 32'd0);
      reset = 1'b1;
      step();

      // out-of-order completion, in-order retire
      alloc_n(3);
      wb1(2, 4'd2);
      check("t2_wait", 32'(commit_valid_out), 32'd0);
      wb1(0, 4'd0);
      check("t2_c0", 32'({commit_valid_out, curr_rob_tag}), 32'({1'b1, 4'd0}));
      wb1(1, 4'd1);
      check("t2_c1", 32'({commit_valid_out, curr_rob_tag}), 32'({1'b1, 4'd1}));
      step();
      check("t2_c2", 32'({commit_valid_out, curr_rob_tag}), 32'({1'b1, 4'd2}));
      step();
      check("t2_empty", 32'(empty_out), 32'd1);

      // full, then commit reopens ready one cycle later
      do_reset();
      alloc_n(16);
      check("t3_full", 32'(full_out), 32'd1);
      check("t3_ready", 32'(alloc_ready_out), 32'd0);
      alloc_valid_in = 1'b1;
      rand_payload();
      wb_valid = 3'b001;
      wb_tag[3:0] = 4'd0;
      step();
      wb_valid = '0;
      check("t3_commit", 32'(commit_valid_out), 32'd1);
      check("t3_still_blocked", 32'(alloc_ready_out), 32'd0);
      step();
      check("t3_reopen", 32'(alloc_ready_out), 32'd1);
      check("t3_newtag", 32'(alloc_tag_out), 32'd0);
      step();
      alloc_valid_in = 1'b0;
      check("t3_refull", 32'(full_out), 32'd1);
      for (int k = 1; k <= 16; k++) wb1(0, TAG_W'(k));
      step();
      step();
      check("t3_drained", 32'(empty_out), 32'd1);

      // wrap plus mispredict across the wrap point
      do_reset();
      alloc_n(14);
      for (int k = 0; k < 14; k++) wb1(1, TAG_W'(k));
      step();
      step();
      check("t4_head", 32'(curr_rob_tag), 32'd14);
      alloc_n(6);
      check("t4_count6", 32'(count_out), 32'd6);
      br_mispredict = 1'b1;
      br_mispredict_tag = 4'd15;
      wb_valid = 3'b001;
      wb_tag[3:0] = 4'd1;
      alloc_valid_in = 1'b1;
      #1;
      check("t4_ready_low", 32'(alloc_ready_out), 32'd0);
      step();
      clr();
      check("t4_count2", 32'(count_out), 32'd2);
      check("t4_tail", 32'(alloc_tag_out), 32'd0);
      wb1(2, 4'd1);
      wb1(1, 4'd14);
      wb1(1, 4'd15);
      step();
      check("t4_empty", 32'(empty_out), 32'd1);
      alloc_n(2);
      wb1(0, 4'd0);
      step();
      check("t4_tag1_notdone", 32'({commit_valid_out, curr_rob_tag}), 32'({1'b0, 4'd1}));
      wb1(0, 4'd1);
      step();

      // multi-channel writeback, duplicate tag
      do_reset();
      alloc_n(6);
      wb_valid = 3'b111;
      wb_tag = {4'd5, 4'd3, 4'd3};
      step();
      wb_valid = '0;
      wb1(0, 4'd0);
      wb1(0, 4'd1);
      wb1(0, 4'd2);
      wb1(0, 4'd4);
      step();
      step();
      step();
      check("t5_empty", 32'(empty_out), 32'd1);
      check("t5_head", 32'(curr_rob_tag), 32'd6);

      // commit and flush at the head in the same cycle
      do_reset();
      alloc_n(7);
      for (int k = 0; k < 7; k++) wb1(2, TAG_W'(k));
      step();
      step();
      alloc_n(3);
      wb1(1, 4'd7);
      br_mispredict = 1'b1;
      br_mispredict_tag = 4'd7;
      #1;
      check("t6_commit", 32'({commit_valid_out, curr_rob_tag}), 32'({1'b1, 4'd7}));
      step();
      clr();
      check("t6_count", 32'(count_out), 32'd0);
      check("t6_head", 32'(curr_rob_tag), 32'd8);
      check("t6_tail", 32'(alloc_tag_out), 32'd8);
      step();

      // random traffic
      for (int c = 0; c < 400; c++) begin
         alloc_valid_in    = ($urandom_range(0, 3) != 0);
         rand_payload();
         wb_valid          = NUM_WB'($urandom);
         wb_tag            = (NUM_WB*TAG_W)'($urandom);
         br_mispredict     = ($urandom_range(0, 19) == 0);
         br_mispredict_tag = TAG_W'($urandom);
         step();
      end
      clr();
      for (int c = 0; c < 40; c++) begin
         wb_valid = 3'b111;
         wb_tag = {TAG_W'(3*c + 2), TAG_W'(3*c + 1), TAG_W'(3*c)};
         step();
      end
      clr();
      step();
      step();
      check("rand_drained", 32'(empty_out), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
